// File: rtl/pong_pkg.sv
// Shared definitions for the pong match sequencer: state codes, player and
// serve-direction encodings, field geometry defaults and a score helper.
package pong_pkg;

   // State codes as seen on the state output port
   localparam logic [2:0] STATE_IDLE_CODE  = 3'd0;
   localparam logic [2:0] STATE_SERVE_CODE = 3'd1;
   localparam logic [2:0] STATE_PLAY_CODE  = 3'd2;
   localparam logic [2:0] STATE_POINT_CODE = 3'd3;
   localparam logic [2:0] STATE_OVER_CODE  = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE  = STATE_IDLE_CODE,
      ST_SERVE = STATE_SERVE_CODE,
      ST_PLAY  = STATE_PLAY_CODE,
      ST_POINT = STATE_POINT_CODE,
      ST_OVER  = STATE_OVER_CODE
   } match_state_t;

   // Player A defends the top edge, player B the bottom edge
   localparam logic PLAYER_A = 1'b0;
   localparam logic PLAYER_B = 1'b1;

   // Launch direction after a point: toward the player who just conceded
   localparam logic DIR_TOWARD_A = 1'b0;
   localparam logic DIR_TOWARD_B = 1'b1;

   // Field geometry and timing defaults (60 Hz frame at 100 MHz)
   localparam int FRAME_DIV_DEF    = 1666666;
   localparam int FIELD_H_DEF      = 480;
   localparam int WIN_SCORE_DEF    = 7;
   localparam int SERVE_FRAMES_DEF = 60;
   localparam int POINT_FRAMES_DEF = 90;

   localparam int SCORE_W  = 4;
   localparam int POS_W    = 10;
   localparam int HEIGHT_W = 8;

   // Saturating score increment: a score never climbs past the winning total
   function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] score,
                                                    input logic [SCORE_W-1:0] limit);
      if (score < limit) begin
         return score + SCORE_W'(1);
      end
      return score;
   endfunction

endpackage

// File: rtl/pong_match_ctrl_frame_tick_gen.sv
// Frame divider: free-running counter producing a registered one-cycle pulse
// once every FRAME_DIV clock cycles.
module frame_tick_gen
   import pong_pkg::*;
#(
   parameter int FRAME_DIV = FRAME_DIV_DEF
) (
   input  logic clk,
   input  logic reset,
   output logic frame_tick
);

   localparam int CNT_W = (FRAME_DIV > 2) ? $clog2(FRAME_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             tick_q;
   logic             tick_d;

   // Next count and pulse: the pulse lands in the cycle after the last count
   always_comb begin
      cnt_d  = cnt_q + CNT_W'(1);
      tick_d = 1'b0;
      if (cnt_q == CNT_LAST) begin
         cnt_d  = '0;
         tick_d = 1'b1;
      end
   end

   // Counter and pulse registers
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign frame_tick = tick_q;

endmodule

// File: rtl/pong_match_ctrl.sv
// Match sequencer for the pong datapath: frame timing, serve/point pauses,
// miss detection at the top and bottom field edges, scoring and winner.
module pong_match_ctrl
   import pong_pkg::*;
#(
   parameter int FRAME_DIV    = FRAME_DIV_DEF,
   parameter int FIELD_H      = FIELD_H_DEF,
   parameter int WIN_SCORE    = WIN_SCORE_DEF,
   parameter int SERVE_FRAMES = SERVE_FRAMES_DEF,
   parameter int POINT_FRAMES = POINT_FRAMES_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                pause,
   input  logic [POS_W-1:0]    ball_pos_y,
   input  logic [HEIGHT_W-1:0] ball_height,
   output logic                frame_tick,
   output logic                phys_tick,
   output logic                ball_rst,
   output logic                serve_dir,
   output logic [SCORE_W-1:0]  score_a,
   output logic [SCORE_W-1:0]  score_b,
   output logic                game_over,
   output logic                winner,
   output logic [2:0]          state
);

   // One counter serves both the serve hold and the point pause
   localparam int PHASE_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
   localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
   localparam logic [PHASE_W-1:0] SERVE_LAST = PHASE_W'(SERVE_FRAMES - 1);
   localparam logic [PHASE_W-1:0] POINT_LAST = PHASE_W'(POINT_FRAMES - 1);
   localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);
   localparam logic [POS_W:0]     FIELD_LIM = (POS_W + 1)'(FIELD_H);

   match_state_t         state_q;
   match_state_t         state_d;
   logic [PHASE_W-1:0]   phase_q;
   logic [PHASE_W-1:0]   phase_d;
   logic [SCORE_W-1:0]   score_a_q;
   logic [SCORE_W-1:0]   score_a_d;
   logic [SCORE_W-1:0]   score_b_q;
   logic [SCORE_W-1:0]   score_b_d;
   logic                 serve_dir_q;
   logic                 serve_dir_d;
   logic                 winner_q;
   logic                 winner_d;
   logic                 start_q;

   logic                 start_rise;
   logic [POS_W:0]       ball_bottom;
   logic                 miss_top;
   logic                 miss_bot;

   frame_tick_gen #(
      .FRAME_DIV (FRAME_DIV)
   ) u_frame_tick_gen (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick)
   );

   assign start_rise = start & ~start_q;

   // Bottom edge uses one extra bit so y + height cannot wrap
   assign ball_bottom = {1'b0, ball_pos_y} + {{(POS_W + 1 - HEIGHT_W){1'b0}}, ball_height};
   assign miss_top    = (ball_pos_y == '0);
   assign miss_bot    = (ball_bottom >= FIELD_LIM);

   // Physics only advances on frame ticks while playing and not paused
   assign phys_tick = frame_tick & (state_q == ST_PLAY) & ~pause;

   // Next-state, tick-phase and scoring logic
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      score_a_d   = score_a_q;
      score_b_d   = score_b_q;
      serve_dir_d = serve_dir_q;
      winner_d    = winner_q;

      unique case (state_q)
         ST_IDLE: begin
            score_a_d = '0;
            score_b_d = '0;
            phase_d   = '0;
            if (start_rise) begin
               state_d = ST_SERVE;
            end
         end

         ST_SERVE: begin
            if (frame_tick) begin
               if (phase_q == SERVE_LAST) begin
                  phase_d = '0;
                  state_d = ST_PLAY;
               end else begin
                  phase_d = phase_q + PHASE_W'(1);
               end
            end
         end

         ST_PLAY: begin
            // A top miss takes priority when both edges are touched
            if (phys_tick) begin
               if (miss_top) begin
                  score_b_d   = score_inc(score_b_q, WIN);
                  serve_dir_d = DIR_TOWARD_A;
                  phase_d     = '0;
                  state_d     = ST_POINT;
               end else if (miss_bot) begin
                  score_a_d   = score_inc(score_a_q, WIN);
                  serve_dir_d = DIR_TOWARD_B;
                  phase_d     = '0;
                  state_d     = ST_POINT;
               end
            end
         end

         ST_POINT: begin
            if (frame_tick) begin
               if (phase_q == POINT_LAST) begin
                  phase_d = '0;
                  if (score_a_q == WIN) begin
                     winner_d = PLAYER_A;
                     state_d  = ST_OVER;
                  end else if (score_b_q == WIN) begin
                     winner_d = PLAYER_B;
                     state_d  = ST_OVER;
                  end else begin
                     state_d  = ST_SERVE;
                  end
               end else begin
                  phase_d = phase_q + PHASE_W'(1);
               end
            end
         end

         ST_OVER: begin
            // Scores clear together with the return to IDLE
            if (start_rise) begin
               score_a_d   = '0;
               score_b_d   = '0;
               serve_dir_d = DIR_TOWARD_A;
               winner_d    = PLAYER_A;
               state_d     = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, counters, scores and start edge detector
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         phase_q     <= '0;
         score_a_q   <= '0;
         score_b_q   <= '0;
         serve_dir_q <= DIR_TOWARD_A;
         winner_q    <= PLAYER_A;
         start_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         score_a_q   <= score_a_d;
         score_b_q   <= score_b_d;
         serve_dir_q <= serve_dir_d;
         winner_q    <= winner_d;
         start_q     <= start;
      end
   end

   assign ball_rst  = (state_q != ST_PLAY);
   assign game_over = (state_q == ST_OVER);
   assign serve_dir = serve_dir_q;
   assign winner    = winner_q;
   assign score_a   = score_a_q;
   assign score_b   = score_b_q;
   assign state     = state_q;

endmodule
